// File: rtl/weight_s2p_buffer.sv
// Serial-to-parallel weight buffer: assembles a stream of elements into
// S2P_SIZE x S2P_SIZE tiles using two ping-pong banks.
module weight_s2p_buffer #(
  parameter int unsigned S2P_SIZE   = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_flush,
  input  logic [DATA_WIDTH-1:0]                  i_data,
  input  logic                                   i_valid,
  input  logic                                   i_pad,
  output logic                                   o_stall,
  output logic [S2P_SIZE*S2P_SIZE*DATA_WIDTH-1:0] o_tile_data,
  output logic                                   o_tile_valid,
  input  logic                                   i_tile_ready,
  output logic [CNT_WIDTH-1:0]                   o_tile_cnt,
  output logic                                   o_overflow
);

  localparam int unsigned Elems = S2P_SIZE * S2P_SIZE;
  localparam int unsigned IdxW  = (S2P_SIZE > 1) ? $clog2(S2P_SIZE) : 1;
  localparam int unsigned AddrW = (Elems > 1) ? $clog2(Elems) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(S2P_SIZE - 1);

  logic [DATA_WIDTH-1:0] mem_q [2][Elems];
  logic [DATA_WIDTH-1:0] mem_d [2][Elems];
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [1:0]            bank_full_q, bank_full_d;
  logic [IdxW-1:0]       col_q, col_d;
  logic [IdxW-1:0]       row_q, row_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;

  logic             accept;
  logic             tile_last;
  logic             handshake;
  logic [AddrW-1:0] waddr;

  assign o_stall      = bank_full_q[wr_bank_q];
  assign o_tile_valid = bank_full_q[rd_bank_q];
  assign o_tile_cnt   = cnt_q;
  assign o_overflow   = ovf_q;

  for (genvar i = 0; i < Elems; i++) begin : g_tile_out
    assign o_tile_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_bank_q][i];
  end

  always_comb begin
    accept      = i_valid & ~o_stall;
    tile_last   = accept & (row_q == LastIdx) & (col_q == LastIdx);
    handshake   = o_tile_valid & i_tile_ready;
    waddr       = AddrW'(row_q) * AddrW'(S2P_SIZE) + AddrW'(col_q);
    mem_d       = mem_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    bank_full_d = bank_full_q;
    col_d       = col_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;

    if (i_flush) begin
      // Flush wins over a same-cycle write and handshake; bank data is kept.
      wr_bank_d   = 1'b0;
      rd_bank_d   = 1'b0;
      bank_full_d = 2'b00;
      col_d       = '0;
      row_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
    end else begin
      if (accept) begin
        mem_d[wr_bank_q][waddr] = i_pad ? '0 : i_data;
        if (col_q == LastIdx) begin
          col_d = '0;
          row_d = (row_q == LastIdx) ? '0 : row_q + IdxW'(1);
        end else begin
          col_d = col_q + IdxW'(1);
        end
        if (tile_last) begin
          bank_full_d[wr_bank_q] = 1'b1;
          wr_bank_d              = ~wr_bank_q;
        end
      end
      if (i_valid && o_stall) begin
        ovf_d = 1'b1;
      end
      // A filling bank is never the bank being drained, so both updates can land together.
      if (handshake) begin
        bank_full_d[rd_bank_q] = 1'b0;
        rd_bank_d              = ~rd_bank_q;
        cnt_d                  = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < Elems; e++) begin
          mem_q[b][e] <= '0;
        end
      end
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
      col_q       <= '0;
      row_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      bank_full_q <= bank_full_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_weight_s2p_buffer.sv
// Scoreboard bench for weight_s2p_buffer: a tile-level model predicts delivered
// tiles, stall and overflow; a negedge monitor compares what the DUT presents.
module tb_weight_s2p_buffer;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int NE = N * N;
  localparam int TW = NE * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_flush = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic          i_pad = 1'b0;
  logic          i_tile_ready = 1'b0;
  logic          o_stall;
  logic [TW-1:0] o_tile_data;
  logic          o_tile_valid;
  logic [CW-1:0] o_tile_cnt;
  logic          o_overflow;

  always #5 clk = ~clk;

  weight_s2p_buffer #(
    .S2P_SIZE  (N),
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (i_flush),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_pad       (i_pad),
    .o_stall     (o_stall),
    .o_tile_data (o_tile_data),
    .o_tile_valid(o_tile_valid),
    .i_tile_ready(i_tile_ready),
    .o_tile_cnt  (o_tile_cnt),
    .o_overflow  (o_overflow)
  );

  int            errors = 0;
  int            checks = 0;
  logic [TW-1:0] exp_q[$];
  logic [DW-1:0] part[$];
  int            model_full = 0;
  logic          exp_ovf = 1'b0;
  logic [CW-1:0] delivered = '0;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    part.delete();
    model_full = 0;
    exp_ovf    = 1'b0;
    delivered  = '0;
  endtask

  // One clock of stimulus; the model advances on the same edge as the DUT.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic p, input logic r,
                      input logic f);
    logic          stall_m;
    logic          hs;
    logic [TW-1:0] t;
    i_valid      = v;
    i_data       = d;
    i_pad        = p;
    i_tile_ready = r;
    i_flush      = f;
    @(posedge clk);
    if (f) begin
      model_clear();
    end else begin
      stall_m = (model_full == 2);
      hs      = (model_full > 0) && r;
      if (v && stall_m) exp_ovf = 1'b1;
      if (v && !stall_m) begin
        part.push_back(p ? '0 : d);
        if (part.size() == NE) begin
          t = '0;
          for (int i = 0; i < NE; i++) t[i*DW +: DW] = part[i];
          exp_q.push_back(t);
          model_full++;
          part.delete();
        end
      end
      if (hs) model_full--;
    end
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) step(1'b0, '0, 1'b0, r, 1'b0);
  endtask

  task automatic feed_rand(input int n, input logic r);
    repeat (n) step(1'b1, DW'($urandom), 1'b0, r, 1'b0);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    #2;
    model_clear();
    chk("rst_tile_valid", TW'(o_tile_valid), '0);
    chk("rst_stall", TW'(o_stall), '0);
    chk("rst_tile_cnt", TW'(o_tile_cnt), '0);
    chk("rst_overflow", TW'(o_overflow), '0);
    chk("rst_tile_data", o_tile_data, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("tile_valid", TW'(o_tile_valid), TW'(model_full > 0));
      chk("stall", TW'(o_stall), TW'(model_full == 2));
      chk("tile_cnt", TW'(o_tile_cnt), TW'(delivered));
      chk("overflow", TW'(o_overflow), TW'(exp_ovf));
      if (o_tile_valid && i_tile_ready && !i_flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tile_unexpected: got a tile, expected none");
        end else begin
          chk("tile_data", o_tile_data, exp_q.pop_front());
        end
        delivered++;
      end
    end
  end

  initial begin
    do_reset();

    // Ramp tile: element k carries value k, so (r,c) reads 8r+c.
    for (int k = 0; k < NE; k++) step(1'b1, DW'(k), 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Padding on columns 5..7.
    for (int k = 0; k < NE; k++) step(1'b1, DW'($urandom), (k % N) >= 5, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Both banks fill with no drain, then one dropped element.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    feed_rand(2 * NE, 1'b0);
    feed_rand(1, 1'b0);
    @(negedge clk);
    chk("overflow_set", TW'(o_overflow), TW'(1));
    idle(2, 1'b1);
    idle(1, 1'b0);
    chk("cnt_after_two", TW'(o_tile_cnt), TW'(2));
    chk("stall_after_drain", TW'(o_stall), '0);

    // Continuous streaming of ten tiles.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10 * NE; k++) step(1'b1, DW'($urandom), ($urandom_range(0, 7) == 0), 1'b1, 1'b0);
    idle(2, 1'b1);
    chk("cnt_after_stream", TW'(o_tile_cnt), TW'(10));

    // Reset in the middle of a tile.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    feed_rand(30, 1'b1);
    do_reset();
    feed_rand(NE, 1'b1);
    idle(2, 1'b1);

    // Flush coinciding with the last element of a tile.
    feed_rand(NE - 1, 1'b1);
    step(1'b1, DW'($urandom), 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush_tile_valid", TW'(o_tile_valid), '0);
    chk("flush_tile_cnt", TW'(o_tile_cnt), '0);
    feed_rand(NE, 1'b1);
    idle(2, 1'b1);

    // Random traffic with occasional flushes.
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 299) == 0);
    end
    idle(3, 1'b1);
    chk("queue_empty", TW'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/weight_s2p_buffer.md
WEIGHT_S2P_BUFFER -- requirements
Module: weight_s2p_buffer

Interface
REQ-001 The block SHALL have parameter S2P_SIZE, default 8, meaning tile edge length in elements, equal to the S2P_SIZE of the weight address generator.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning bits per weight element.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, meaning the width of the delivered-tile counter.
REQ-004 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous and active-high.
REQ-006 Port: i_flush  input  1  synchronous clear of all fill/drain state.
REQ-007 Port: i_data  input  DATA_WIDTH  weight memory read data, aligned with i_valid.
REQ-008 Port: i_valid  input  1  i_data carries the element for the next tile position (registered address-valid from the address generator).
REQ-009 Port: i_pad  input  1  the current element is padding; aligned with i_valid.
REQ-010 Port: o_stall  output  1  the write bank is full; upstream SHALL drop enable.
REQ-011 Port: o_tile_data  output  S2P_SIZE*S2P_SIZE*DATA_WIDTH  read-bank tile in row-major order; element (r,c) at bits [(r*S2P_SIZE+c)*DATA_WIDTH +: DATA_WIDTH].
REQ-012 Port: o_tile_valid  output  1  o_tile_data holds a complete tile.
REQ-013 Port: i_tile_ready  input  1  the downstream array accepts the tile.
REQ-014 Port: o_tile_cnt  output  CNT_WIDTH  number of tiles delivered, modulo 2^CNT_WIDTH.
REQ-015 Port: o_overflow  output  1  sticky flag: an element arrived while o_stall was high.

Function
REQ-016 The block SHALL hold two tile banks (ping-pong) plus the following state: wr_bank, rd_bank (1 bit each), bank_full[1:0], col_cnt and row_cnt (0..S2P_SIZE-1).
REQ-017 o_stall SHALL be combinational: bank_full[wr_bank].
REQ-018 An element SHALL be accepted when i_valid=1 and o_stall=0.
REQ-019 An accepted element SHALL be written to bank wr_bank at (row_cnt,col_cnt), with value 0 if i_pad=1, otherwise i_data.
REQ-020 On acceptance, col_cnt SHALL increment; at S2P_SIZE-1 it SHALL wrap to 0 and row_cnt SHALL increment.
REQ-021 When row_cnt=col_cnt=S2P_SIZE-1 on acceptance, the block SHALL set bank_full[wr_bank], toggle wr_bank, and return both counters to 0.
REQ-022 i_valid=1 while o_stall=1 SHALL discard the element, leave all counters unchanged, and set o_overflow until rst or i_flush.
REQ-023 o_tile_valid SHALL equal bank_full[rd_bank]; o_tile_data SHALL be driven from bank rd_bank.
REQ-024 Latency: when the last element of a tile is accepted in cycle N, o_tile_valid SHALL be 1 in cycle N+1.
REQ-025 When o_tile_valid=1 and i_tile_ready=1, the block SHALL clear bank_full[rd_bank], toggle rd_bank, and increment o_tile_cnt (wrapping).
REQ-026 o_tile_valid and o_tile_data SHALL stay stable until the handshake completes; i_tile_ready while o_tile_valid=0 SHALL have no effect.
REQ-027 If one bank completes filling and the other bank is drained in the same cycle, both updates SHALL take effect.
REQ-028 Accepting into one bank while the other is being drained SHALL proceed without a stall.
REQ-029 Per bank: EMPTY -> FILLING on first write; FILLING -> FULL on last write; FULL -> EMPTY on handshake. Bank contents are not cleared when the bank drains.
REQ-030 i_flush=1 SHALL clear bank_full, wr_bank, rd_bank, col_cnt, row_cnt, o_tile_cnt and o_overflow in the next cycle, with priority over simultaneous acceptance and handshake. Bank data MAY be left unchanged.

Reset
REQ-031 Asserting rst SHALL immediately force wr_bank=0, rd_bank=0, bank_full=0, col_cnt=0, row_cnt=0, o_tile_cnt=0, o_overflow=0, o_tile_valid=0 and o_stall=0.
REQ-032 Bank data SHALL reset to 0.
REQ-033 Reset asserted mid-tile SHALL discard the partial tile; the first accepted element after release SHALL go to bank 0 at (0,0).

Verification
REQ-034 Scenario: S2P_SIZE=8; feed 64 elements of value k (k=0..63), i_tile_ready=1 -> o_tile_valid high exactly one cycle, the cycle after element 63; element (r,c)=8r+c; o_tile_cnt=1.
REQ-035 Scenario: feed one tile with i_pad=1 on every element where c>=5 -> columns 5..7 read 0 in all rows; other elements match i_data.
REQ-036 Scenario: hold i_tile_ready=0 and feed 128 elements -> both banks full, o_stall=1 after element 127; a 129th element sets o_overflow=1 and leaves the tile contents unchanged; then ready=1 for two cycles -> tile A then tile B delivered, o_tile_cnt=2, o_stall=0.
REQ-037 Scenario: stream continuously with i_tile_ready=1 for 10 tiles -> no stall, o_tile_cnt=10, rd_bank alternates 0/1 on each tile.
REQ-038 Scenario: assert rst after 30 elements, then feed 64 elements -> the first tile holds only post-reset data, delivered from bank 0.
REQ-039 Scenario: assert i_flush in the same cycle as the last element of a tile and i_tile_ready=1 -> next cycle o_tile_valid=0, o_tile_cnt=0, counters at 0.
